// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, complete by index on two
// ports, retire completed entries from head in program order.

module rob_entry #(
    parameter int PAY_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             alloc_i,
    input  logic             cmpl_i,
    input  logic             retire_i,
    input  logic [PAY_W-1:0] pay_i,
    output logic             valid_o,
    output logic             done_o,
    output logic [PAY_W-1:0] pay_o
);

    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [PAY_W-1:0] pay_q, pay_d;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        pay_d   = pay_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (alloc_i) begin
            valid_d = 1'b1;
            done_d  = 1'b0;
            pay_d   = pay_i;
        end else begin
            if (retire_i) valid_d = 1'b0;
            // strobes aimed at a free slot are stale and must not mark it done
            if (cmpl_i && valid_q) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            pay_q   <= pay_d;
        end
    end

    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign pay_o   = pay_q;

endmodule

module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_W    = 4,
    parameter int PREG_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_rd,
    input  logic [4:0]        alloc_ard,
    input  logic [PREG_W-1:0] alloc_prd,
    input  logic [PREG_W-1:0] alloc_old_prd,
    output logic [ROB_W-1:0]  rob_index,
    input  logic              cmpl0_valid,
    input  logic [ROB_W-1:0]  cmpl0_index,
    input  logic              cmpl1_valid,
    input  logic [ROB_W-1:0]  cmpl1_index,
    input  logic              retire_stall,
    output logic              retire_valid,
    output logic              retire_has_rd,
    output logic [4:0]        retire_ard,
    output logic [PREG_W-1:0] retire_prd,
    output logic [PREG_W-1:0] retire_old_prd,
    input  logic              flush,
    output logic [ROB_W:0]    count,
    output logic              empty
);

    localparam int PAY_W = 6 + 2 * PREG_W;
    localparam logic [ROB_W:0] FULL = ROB_SIZE[ROB_W:0];

    logic [ROB_W-1:0] head_q, head_d;
    logic [ROB_W-1:0] tail_q, tail_d;
    logic [ROB_W:0]   count_q, count_d;

    logic [ROB_SIZE-1:0] ent_valid, ent_done;
    logic [PAY_W-1:0]    ent_pay [ROB_SIZE];
    logic [PAY_W-1:0]    head_pay;
    logic                alloc_fire;

    assign alloc_ready  = (count_q != FULL);
    assign alloc_fire   = alloc_valid && alloc_ready && !flush;
    assign retire_valid = ent_valid[head_q] && ent_done[head_q] && !retire_stall && !flush;

    genvar g;
    generate
        for (g = 0; g < ROB_SIZE; g++) begin : g_ent
            rob_entry #(.PAY_W(PAY_W)) u_ent (
                .clk      (clk),
                .rst      (rst),
                .flush_i  (flush),
                .alloc_i  (alloc_fire && (tail_q == ROB_W'(g))),
                .cmpl_i   ((cmpl0_valid && (cmpl0_index == ROB_W'(g))) ||
                           (cmpl1_valid && (cmpl1_index == ROB_W'(g)))),
                .retire_i (retire_valid && (head_q == ROB_W'(g))),
                .pay_i    ({alloc_has_rd, alloc_ard, alloc_prd, alloc_old_prd}),
                .valid_o  (ent_valid[g]),
                .done_o   (ent_done[g]),
                .pay_o    (ent_pay[g])
            );
        end
    endgenerate

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire)   tail_d = tail_q + 1'b1;
            if (retire_valid) head_d = head_q + 1'b1;
            count_d = count_q + {{ROB_W{1'b0}}, alloc_fire} - {{ROB_W{1'b0}}, retire_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_pay  = ent_pay[head_q];
    assign {retire_has_rd, retire_ard, retire_prd, retire_old_prd} = head_pay;
    assign rob_index = tail_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation order, completion, retire,
// full/wrap, dual-port completion, flush and stall.

module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid, alloc_ready, alloc_has_rd;
    logic [4:0] alloc_ard;
    logic [6:0] alloc_prd, alloc_old_prd;
    logic [3:0] rob_index;
    logic       cmpl0_valid, cmpl1_valid;
    logic [3:0] cmpl0_index, cmpl1_index;
    logic       retire_stall, retire_valid, retire_has_rd;
    logic [4:0] retire_ard;
    logic [6:0] retire_prd, retire_old_prd;
    logic       flush;
    logic [4:0] count;
    logic       empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_rd(alloc_has_rd), .alloc_ard(alloc_ard),
        .alloc_prd(alloc_prd), .alloc_old_prd(alloc_old_prd),
        .rob_index(rob_index),
        .cmpl0_valid(cmpl0_valid), .cmpl0_index(cmpl0_index),
        .cmpl1_valid(cmpl1_valid), .cmpl1_index(cmpl1_index),
        .retire_stall(retire_stall), .retire_valid(retire_valid),
        .retire_has_rd(retire_has_rd), .retire_ard(retire_ard),
        .retire_prd(retire_prd), .retire_old_prd(retire_old_prd),
        .flush(flush), .count(count), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_has_rd = 0; alloc_ard = 0; alloc_prd = 0; alloc_old_prd = 0;
        cmpl0_valid = 0; cmpl0_index = 0; cmpl1_valid = 0; cmpl1_index = 0;
        retire_stall = 0; flush = 0;
    endtask

    task automatic alloc(input logic [6:0] prd);
        alloc_valid = 1; alloc_has_rd = 1; alloc_ard = prd[4:0];
        alloc_prd = prd; alloc_old_prd = prd + 7'd1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_flush();
        idle(); flush = 1; cyc(); idle();
    endtask

    initial begin
        idle();
        rst = 0;
        cyc(); cyc();
        rst = 1;
        #1;
        chk("rst_index", rob_index, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_rv", retire_valid, 0);
        chk("rst_prd", retire_prd, 0);
        chk("rst_old", retire_old_prd, 0);
        chk("rst_ard", retire_ard, 0);
        chk("rst_hasrd", retire_has_rd, 0);

        // basic allocate / out-of-order complete / in-order retire
        for (int i = 0; i < 3; i++) begin
            alloc(7'(10 + i)); #1;
            chk("t1_index", rob_index, i);
            cyc();
        end
        idle(); cmpl0_valid = 1; cmpl0_index = 1; #1;
        chk("t1_rv_d", retire_valid, 0);
        cyc();
        idle(); cmpl1_valid = 1; cmpl1_index = 0; #1;
        chk("t1_nobypass", retire_valid, 0);
        chk("t1_count3", count, 3);
        cyc();
        idle(); #1;
        chk("t1_rv0", retire_valid, 1);
        chk("t1_prd0", retire_prd, 10);
        chk("t1_ard0", retire_ard, 10);
        chk("t1_old0", retire_old_prd, 11);
        cyc();
        chk("t1_rv1", retire_valid, 1);
        chk("t1_prd1", retire_prd, 11);
        cyc();
        chk("t1_hold2", retire_valid, 0);
        chk("t1_count1", count, 1);
        do_flush();

        // fill to full, retire one, refill wraps tail to 0
        for (int i = 0; i < 16; i++) begin
            alloc(7'(32 + i)); #1;
            chk("t2_index", rob_index, i);
            cyc();
        end
        idle(); alloc(7'd99); cmpl0_valid = 1; cmpl0_index = 0; #1;
        chk("t2_full_rdy", alloc_ready, 0);
        chk("t2_full_cnt", count, 16);
        cyc();
        chk("t2_rv", retire_valid, 1);
        chk("t2_rprd", retire_prd, 32);
        chk("t2_rdy_same", alloc_ready, 0);
        cyc();
        chk("t2_rdy_after", alloc_ready, 1);
        chk("t2_cnt15", count, 15);
        chk("t2_idx17", rob_index, 0);
        cyc();
        idle(); #1;
        chk("t2_refull", count, 16);
        chk("t2_rdy0", alloc_ready, 0);
        do_flush();

        // streaming: alloc k, complete k at k+1, retire k at k+2
        for (int k = 0; k < 42; k++) begin
            idle();
            if (k < 40) alloc(7'(50 + k));
            if (k >= 1 && k <= 40) begin
                cmpl0_valid = 1; cmpl0_index = 4'((k - 1) & 15);
            end
            #1;
            if (k < 40) chk("t3_index", rob_index, k & 15);
            chk("t3_rv", retire_valid, (k >= 2) ? 1 : 0);
            if (k >= 2) chk("t3_prd", retire_prd, 50 + k - 2);
            cyc();
        end
        idle(); #1;
        chk("t3_empty", empty, 1);
        chk("t3_rv_end", retire_valid, 0);
        do_flush();

        // dual-port completion with head at 3
        for (int i = 0; i < 8; i++) begin
            alloc(7'(100 + i)); cyc();
        end
        idle(); cmpl0_valid = 1; cmpl0_index = 0; cmpl1_valid = 1; cmpl1_index = 1; cyc();
        idle(); cmpl0_valid = 1; cmpl0_index = 2; #1;
        chk("t4_r0", retire_prd, 100);
        cyc();
        idle(); #1;
        chk("t4_r1", retire_prd, 101);
        cyc();
        chk("t4_r2", retire_prd, 102);
        chk("t4_r2v", retire_valid, 1);
        cyc();
        cmpl0_valid = 1; cmpl0_index = 3; cmpl1_valid = 1; cmpl1_index = 5; #1;
        chk("t4_h3_wait", retire_valid, 0);
        cyc();
        idle(); #1;
        chk("t4_r3v", retire_valid, 1);
        chk("t4_r3", retire_prd, 103);
        cyc();
        cmpl0_valid = 1; cmpl0_index = 4; cmpl1_valid = 1; cmpl1_index = 4; #1;
        chk("t4_blk4", retire_valid, 0);
        cyc();
        idle(); #1;
        chk("t4_r4v", retire_valid, 1);
        chk("t4_r4", retire_prd, 104);
        cyc();
        chk("t4_r5v", retire_valid, 1);
        chk("t4_r5", retire_prd, 105);
        cyc();
        chk("t4_blk6", retire_valid, 0);
        chk("t4_cnt", count, 2);
        do_flush();

        // flush beats same-cycle alloc/complete; stale completion ignored
        for (int i = 0; i < 6; i++) begin
            alloc(7'(60 + i)); cyc();
        end
        idle(); cmpl0_valid = 1; cmpl0_index = 0; cyc();
        idle(); flush = 1; alloc(7'd70); cmpl1_valid = 1; cmpl1_index = 1; #1;
        chk("t5_rv_flush", retire_valid, 0);
        cyc();
        idle(); #1;
        chk("t5_cnt", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_index", rob_index, 0);
        chk("t5_rv", retire_valid, 0);
        cmpl0_valid = 1; cmpl0_index = 2;
        cyc();
        idle(); #1;
        chk("t5_cnt2", count, 0);
        alloc(7'd80); cyc();
        alloc(7'd81); cyc();
        alloc(7'd82); cyc();
        idle(); #1;
        chk("t5_nodone", retire_valid, 0);
        chk("t5_cnt3", count, 3);
        do_flush();

        // retire_stall holds a done head
        alloc(7'd90); cyc();
        idle(); cmpl0_valid = 1; cmpl0_index = 0; cyc();
        idle(); retire_stall = 1; #1;
        chk("t6_stall_rv", retire_valid, 0);
        cyc();
        chk("t6_stall_cnt", count, 1);
        chk("t6_stall_rv2", retire_valid, 0);
        retire_stall = 0; #1;
        chk("t6_go_rv", retire_valid, 1);
        chk("t6_go_prd", retire_prd, 90);
        cyc();
        chk("t6_cnt0", count, 0);
        chk("t6_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order reorder buffer for the out-of-order core. Dispatch allocates one entry per cycle at the tail, and the tail index is driven to the issue queue as each instruction's `rob_index`. Functional units report completion by ROB index on up to two ports. Completed entries retire strictly in program order from the head, which releases the stale physical register back to rename.

## Interface
- `ROB_SIZE`, 16, number of entries; must be a power of two.
- `ROB_W`, 4, log2(`ROB_SIZE`); width of every ROB index.
- `PREG_W`, 7, physical register tag width; matches the issue queue `prd` width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `alloc_valid`  in  1  dispatch presents an instruction.
- `alloc_ready`  out  1  an entry is free; high when count < `ROB_SIZE`.
- `alloc_has_rd`  in  1  the instruction writes a destination register.
- `alloc_ard`  in  5  architectural destination register.
- `alloc_prd`  in  `PREG_W`  newly mapped physical destination.
- `alloc_old_prd`  in  `PREG_W`  previous mapping of `alloc_ard`; freed at retire.
- `rob_index`  out  `ROB_W`  current tail; the index the next allocation receives.
- `cmpl0_valid`, `cmpl1_valid`  in  1  completion strobes, one per issue port.
- `cmpl0_index`, `cmpl1_index`  in  `ROB_W`  index of the completing entry.
- `retire_stall`  in  1  holds retirement (commit side busy).
- `retire_valid`  out  1  the head entry retires at this clock edge.
- `retire_has_rd`  out  1  has_rd field of the retiring entry.
- `retire_ard`  out  5  ard field of the retiring entry.
- `retire_prd`  out  `PREG_W`  prd field of the retiring entry.
- `retire_old_prd`  out  `PREG_W`  old_prd field of the retiring entry.
- `flush`  in  1  discard all entries (mispredict/exception).
- `count`  out  `ROB_W`+1  number of occupied entries.
- `empty`  out  1  high when count == 0.

## Operation
- State:
  - `head` and `tail` pointers, `ROB_W` bits each; they wrap modulo `ROB_SIZE`.
  - `count` register, `ROB_W`+1 bits.
  - Per entry: `valid` bit, `done` bit, and payload (has_rd, ard, prd, old_prd).
- Allocate: fires when `alloc_valid && alloc_ready`.
  - Entry[tail] gets valid=1, done=0 and the payload.
  - `tail` increments.
  - The value on `rob_index` during the allocating cycle is the index that entry receives.
- Complete: `cmpl*_valid` sets done[index] only if valid[index]=1. A strobe to an invalid entry is ignored. Both ports may hit different entries in the same cycle. Both ports hitting the same index is legal and sets done once.
- Retire: `retire_valid = valid[head] && done[head] && !retire_stall && !flush`, combinational.
  - When high: valid[head] clears and `head` increments at the edge.
  - `retire_*` payload outputs always reflect entry[head]. They are meaningful only when `retire_valid` is high.
  - At most one retirement per cycle.
- Count update: `count` += alloc fire, −= retire fire. Simultaneous allocate and retire leaves count unchanged.
- Flush (synchronous) has priority over everything else in the cycle:
  - `head`, `tail` and `count` go to 0; all valid bits clear.
  - Allocation, completion and retirement that cycle are dropped.
- Reset (`rst`=0) behaves identically to flush. All done bits and payloads also clear to 0.

## Timing
- After reset:
  - `rob_index`=0, `count`=0, `empty`=1, `alloc_ready`=1.
  - `retire_valid`=0, all `retire_*` payload outputs =0.
- Allocate→visible: an entry allocated in cycle N may be completed by a strobe in cycle N+1 at the earliest.
- Complete→retire: a completion of the head entry in cycle N gives `retire_valid`=1 in cycle N+1. Completion is not bypassed to retire.
- Full:
  - `alloc_ready` is computed from registered `count` only. A retire in the same cycle does not reopen a slot.
  - When `count`=16, the next allocation is possible in the cycle after a retire.
- Empty: `retire_valid`=0 whenever valid[head]=0.
- Wrap: `tail` 15→0 and `head` 15→0 behave like any other increment.
- Reset or flush mid-stream: outputs take their reset values in the cycle after the asserting edge. In-flight completions for discarded indices are ignored.

## Test plan
- Reset, allocate 3 (prd 10, 11, 12), complete index 1 then 0 → `rob_index` reads 0, 1, 2 during allocations. Index 0 retires the cycle after its completion, then index 1 the following cycle. Index 2 is held.
- Allocate 16 with no completions → `alloc_ready`=0 and `count`=16. Complete index 0 → it retires next cycle. `alloc_ready`=1 one cycle later, and the 17th allocation receives `rob_index`=0.
- Steady stream of 40 allocate/complete/retire operations → pointers wrap twice. `retire_prd` order matches allocation order exactly.
- Complete indices 3 and 5 on ports 0 and 1 in the same cycle while head=3 → entry 3 retires. Entry 4 blocks until completed, then entries 4 and 5 retire on consecutive cycles.
- Fill 6 entries, pulse `flush` together with `alloc_valid` and `cmpl0_valid` → next cycle `count`=0, `empty`=1, `rob_index`=0, `retire_valid`=0. A later completion of index 2 has no effect.
- `retire_stall`=1 with head done → `retire_valid`=0 and `count` held. Deassert → retire in the same cycle.
